// File: rtl/base_vdelay_pkg.sv
// base_vdelay_pkg: shared helper for sizing the occupancy counter
package base_vdelay_pkg;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/base_vdelay_stage.sv
// base_vdelay_stage: one pipeline slot, a valid bit plus a data register loaded only on capture
module base_vdelay_stage #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_adv,
    input  logic             i_flush,
    input  logic [width-1:0] i_d,
    output logic             o_v,
    output logic [width-1:0] o_d
);
    logic             r_v;
    logic [width-1:0] r_d;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else begin
            r_v <= ~i_flush & (i_load | (r_v & ~i_adv));
            if (i_load) r_d <= i_d;
        end
    end
    assign o_v = r_v;
    assign o_d = r_d;
endmodule

// File: rtl/base_vdelay.sv
// base_vdelay: elastic n-stage delay line with bubble collapse, flush and occupancy count.
// The ready chain runs combinationally from o_r to i_r, so usable n is bounded by timing.
module base_vdelay
    import base_vdelay_pkg::*;
#(
    parameter int width = 1,
    parameter int n = 1,
    localparam int cw = (clog2(n + 1) > 0) ? clog2(n + 1) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    output logic             i_r,
    input  logic [width-1:0] i_d,
    input  logic             i_flush,
    output logic             o_v,
    input  logic             o_r,
    output logic [width-1:0] o_d,
    output logic [cw-1:0]    o_cnt
);
    generate
        if (n == 0) begin : g_comb
            assign o_v   = i_v & ~i_flush;
            assign i_r   = o_r & ~i_flush;
            assign o_d   = i_d;
            assign o_cnt = '0;
        end else begin : g_pipe
            logic [n-1:0]     w_v;
            logic [n-1:0]     w_adv;
            logic [n-1:0]     w_load;
            logic [width-1:0] w_d [n+1];
            logic [cw-1:0]    r_cnt;
            // Walk from the output back so each stage sees whether its successor moves.
            always_comb begin
                w_adv      = '0;
                w_load     = '0;
                w_adv[n-1] = ~i_flush & w_v[n-1] & o_r;
                for (int k = n - 2; k >= 0; k--)
                    w_adv[k] = ~i_flush & w_v[k] & (~w_v[k+1] | w_adv[k+1]);
                i_r       = ~i_flush & (~w_v[0] | w_adv[0]);
                w_load[0] = i_v & i_r;
                for (int k = 1; k < n; k++)
                    w_load[k] = w_adv[k-1];
            end
            assign w_d[0] = i_d;
            for (genvar g = 0; g < n; g++) begin : g_stage
                base_vdelay_stage #(.width(width)) u_stage (
                    .clk    (clk),
                    .reset  (reset),
                    .i_load (w_load[g]),
                    .i_adv  (w_adv[g]),
                    .i_flush(i_flush),
                    .i_d    (w_d[g]),
                    .o_v    (w_v[g]),
                    .o_d    (w_d[g+1])
                );
            end
            assign o_v = w_v[n-1] & ~i_flush;
            assign o_d = w_d[n];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) r_cnt <= '0;
                else        r_cnt <= i_flush ? '0 : r_cnt + cw'(i_v & i_r) - cw'(o_v & o_r);
            end
            assign o_cnt = r_cnt;
        end
    endgenerate
endmodule

// File: tb/tb_base_vdelay.sv
// tb_base_vdelay: directed and random checks of base_vdelay against a queue-based model
module tb_base_vdelay;
    localparam int N = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       i_v = 1'b0;
    logic       i_flush = 1'b0;
    logic       o_r = 1'b0;
    logic [7:0] i_d = 8'h00;
    logic       i_r, o_v;
    logic [7:0] o_d;
    logic [1:0] o_cnt;

    logic       z_i_v = 1'b0;
    logic       z_flush = 1'b0;
    logic       z_o_r = 1'b0;
    logic [7:0] z_i_d = 8'h00;
    logic       z_i_r, z_o_v;
    logic [7:0] z_o_d;
    logic [0:0] z_cnt;

    base_vdelay #(.width(8), .n(N)) dut (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_flush(i_flush),
        .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_cnt(o_cnt)
    );

    base_vdelay #(.width(8), .n(0)) dut0 (
        .clk(clk), .reset(reset), .i_v(z_i_v), .i_r(z_i_r), .i_d(z_i_d), .i_flush(z_flush),
        .o_v(z_o_v), .o_r(z_o_r), .o_d(z_o_d), .o_cnt(z_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } beat_t;

    beat_t q[$];
    int    cyc = 0;
    int    vectors = 0;
    int    errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: compare mid-cycle against the model, then let the model follow the edge.
    // A beat accepted in cycle c is visible at the output from cycle c+N onward; the line
    // holds at most N beats, so ready is just "room left after this cycle's departure".
    task automatic cycle();
        bit ev, er, in_x, out_x;
        @(negedge clk);
        ev = q.size() > 0 && cyc >= q[0].acc + N && !i_flush;
        er = !i_flush && (q.size() - int'(ev && o_r) < N);
        check("o_v", o_v, ev);
        check("i_r", i_r, er);
        check("o_cnt", o_cnt, q.size());
        if (ev) check("o_d", o_d, q[0].d);
        in_x  = i_v && er;
        out_x = ev && o_r;
        @(posedge clk);
        if (i_flush) q.delete();
        else begin
            if (out_x) void'(q.pop_front());
            if (in_x) q.push_back('{i_d, cyc});
        end
        cyc++;
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        i_v = 1'b1;
        i_d = d;
        cycle();
        i_v = 1'b0;
    endtask

    task automatic idle(input int k);
        i_v = 1'b0;
        for (int j = 0; j < k; j++) cycle();
    endtask

    initial begin
        #1;
        check("rst_o_v", o_v, 0);
        check("rst_o_d", o_d, 0);
        check("rst_o_cnt", o_cnt, 0);
        check("rst_i_r", i_r, 1);
        idle(2);
        reset = 1'b1;

        o_r = 1'b1;
        send(8'h11);
        send(8'h22);
        send(8'h33);
        idle(5);

        o_r = 1'b0;
        send(8'h01);
        send(8'h02);
        send(8'h03);
        i_v = 1'b1;
        i_d = 8'h04;
        cycle();
        check("bp_full_cnt", o_cnt, 3);
        o_r = 1'b1;
        cycle();
        idle(6);

        o_r = 1'b0;
        send(8'hAA);
        idle(3);
        send(8'hBB);
        idle(3);
        check("bubble_cnt", o_cnt, 2);
        check("bubble_hold", o_d, 8'hAA);
        o_r = 1'b1;
        idle(5);

        o_r = 1'b0;
        send(8'hC1);
        send(8'hC2);
        send(8'hC3);
        i_flush = 1'b1;
        i_v = 1'b1;
        i_d = 8'hC4;
        cycle();
        i_flush = 1'b0;
        o_r = 1'b1;
        idle(6);

        for (int j = 0; j < 300; j++) begin
            i_v = 1'($urandom);
            i_d = 8'($urandom);
            o_r = ($urandom_range(3) != 0);
            i_flush = ($urandom_range(31) == 0);
            cycle();
        end
        i_flush = 1'b0;
        o_r = 1'b1;
        idle(5);

        send(8'hE1);
        send(8'hE2);
        i_v = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_o_v", o_v, 0);
        check("arst_o_cnt", o_cnt, 0);
        check("arst_o_d", o_d, 0);
        q.delete();
        idle(2);
        reset = 1'b1;
        send(8'h5A);
        idle(4);

        z_i_v = 1'b1;
        z_i_d = 8'h7E;
        for (int j = 0; j < 4; j++) begin
            z_o_r = j[0];
            z_flush = (j == 3);
            #1;
            check("n0_o_v", z_o_v, j != 3);
            check("n0_o_d", z_o_d, 8'h7E);
            check("n0_i_r", z_i_r, j[0] && j != 3);
            check("n0_cnt", z_cnt, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
